seq_multiplier: RTL and testbench

Parametrised sequential shift-and-add multiplier with selectable signed/unsigned mode and valid/ready handshakes on both sides. It reuses the ripple-carry adder structure, one `n_bit_adder` of width N_BITS, iterated over N_BITS cycles instead of a combinational array. It is the next-generation datapath core for the multiplier design, and it trades latency for area so wider operands fit the tile.

---
 rtl/seq_multiplier.sv | 114 +++++++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one N-bit adder iterated over N_BITS cycles,
// signed operands handled as magnitudes with the sign reapplied to the final product.

module n_bit_adder #(
    parameter int unsigned N_BITS = 4
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    input  logic              i_cin,
    output logic [N_BITS-1:0] o_sum,
    output logic              o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N_BITS{1'b0}}, i_cin};
endmodule

module seq_multiplier #(
    parameter int unsigned N_BITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [N_BITS-1:0]     i_a,
    input  logic [N_BITS-1:0]     i_b,
    input  logic                  i_signed,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*N_BITS-1:0]   o_product,
    output logic                  o_busy
);
    localparam int unsigned CW = $clog2(N_BITS);
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_BITS-1:0]     ma_q, ma_d;
    logic                  neg_q, neg_d;
    logic [2*N_BITS-1:0]   p_q, p_d;
    logic [2*N_BITS-1:0]   prod_q, prod_d;

    logic [N_BITS-1:0]     mag_a, mag_b;
    logic [N_BITS-1:0]     add_b, add_sum;
    logic                  add_cout;

    // Most-negative operand negates to itself, which reads correctly as 2^(N-1) unsigned.
    assign mag_a = (i_signed && i_a[N_BITS-1]) ? (~i_a + 1'b1) : i_a;
    assign mag_b = (i_signed && i_b[N_BITS-1]) ? (~i_b + 1'b1) : i_b;
    assign add_b = p_q[0] ? ma_q : '0;

    n_bit_adder #(.N_BITS(N_BITS)) u_adder (
        .i_a    (p_q[2*N_BITS-1:N_BITS]),
        .i_b    (add_b),
        .i_cin  (1'b0),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        neg_d   = neg_q;
        p_d     = p_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = RUN;
                    ma_d    = mag_a;
                    neg_d   = i_signed && (i_a[N_BITS-1] ^ i_b[N_BITS-1]);
                    p_d     = {{N_BITS{1'b0}}, mag_b};
                    cnt_d   = '0;
                end
            end
            RUN: begin
                p_d   = {add_cout, add_sum, p_q[N_BITS-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    prod_d  = neg_q ? (~p_d + 1'b1) : p_d;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
            prod_q  <= prod_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_busy    = ~o_ready;
    assign o_valid   = (state_q == DONE);
    assign o_product = prod_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: N=4 handshake/latency/corner tests plus N=2/8/16 sweeps.

module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int compared = 0;
    int mism     = 0;

    logic        v2, r2, s2, rdy2, vld2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic        v4, r4, s4, rdy4, vld4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        v8, r8, s8, rdy8, vld8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        v16, r16, s16, rdy16, vld16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    seq_multiplier #(.N_BITS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2), .i_a(a2), .i_b(b2),
        .i_signed(s2), .o_valid(vld2), .i_ready(r2), .o_product(p2), .o_busy(busy2));
    seq_multiplier #(.N_BITS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy4), .i_a(a4), .i_b(b4),
        .i_signed(s4), .o_valid(vld4), .i_ready(r4), .o_product(p4), .o_busy(busy4));
    seq_multiplier #(.N_BITS(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_a(a8), .i_b(b8),
        .i_signed(s8), .o_valid(vld8), .i_ready(r8), .o_product(p8), .o_busy(busy8));
    seq_multiplier #(.N_BITS(16)) dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16), .i_a(a16), .i_b(b16),
        .i_signed(s16), .o_valid(vld16), .i_ready(r16), .o_product(p16), .o_busy(busy16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        case (w)
            2:       begin v2 = v;  a2 = a[1:0];  b2 = b[1:0];  s2 = s;  end
            8:       begin v8 = v;  a8 = a[7:0];  b8 = b[7:0];  s8 = s;  end
            16:      begin v16 = v; a16 = a;      b16 = b;      s16 = s; end
            default: begin v4 = v;  a4 = a[3:0];  b4 = b[3:0];  s4 = s;  end
        endcase
    endtask

    function automatic logic rdy_of(input int w);
        case (w)
            2: return rdy2;  8: return rdy8;  16: return rdy16;  default: return rdy4;
        endcase
    endfunction

    function automatic logic vld_of(input int w);
        case (w)
            2: return vld2;  8: return vld8;  16: return vld16;  default: return vld4;
        endcase
    endfunction

    function automatic logic [31:0] prod_of(input int w);
        case (w)
            2: return {28'd0, p2};  8: return {16'd0, p8};  16: return p16;  default: return {24'd0, p4};
        endcase
    endfunction

    // Reference product: interpret operands at width w, multiply as integers, keep 2w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint m, sa, sb, p;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // One full transaction with the downstream always ready; checks latency, result and turnaround.
    task automatic op(input string tag, input int w, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [31:0] exp);
        int n;
        @(negedge clk);
        check({tag, "_ready"}, 32'(rdy_of(w)), 32'd1);
        drive(w, 1'b1, a, b, s);
        @(negedge clk);
        drive(w, 1'b0, '0, '0, 1'b0);
        n = 0;
        while (!vld_of(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(w));
        check({tag, "_product"}, prod_of(w), exp);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(rdy_of(w)), 32'd1);
        check({tag, "_held"}, prod_of(w), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] ra, rb;
        rst = 1'b1;
        r2 = 1'b1; r4 = 1'b1; r8 = 1'b1; r16 = 1'b1;
        for (int w = 2; w <= 16; w = w * 2) drive(w, 1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(vld4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_product", 32'(p4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(rdy4), 32'd1);

        op("u15x15", 4, 16'hF, 16'hF, 1'b0, 32'hE1);
        op("s_m8xm8", 4, 16'h8, 16'h8, 1'b1, 32'h40);
        op("s_m8x7", 4, 16'h8, 16'h7, 1'b1, 32'hC8);
        op("s_7xm1", 4, 16'h7, 16'hF, 1'b1, 32'hF9);
        op("s_0xm8", 4, 16'h0, 16'h8, 1'b1, 32'h00);
        op("u_8x8", 4, 16'h8, 16'h8, 1'b0, 32'h40);
        op("u_8x7", 4, 16'h8, 16'h7, 1'b0, 32'h38);
        op("u_7x15", 4, 16'h7, 16'hF, 1'b0, 32'h69);

        // Back-pressure: result held for 10 cycles, new requests ignored meanwhile.
        r4 = 1'b0;
        @(negedge clk);
        drive(4, 1'b1, 16'h3, 16'h5, 1'b0);
        @(negedge clk);
        drive(4, 1'b0, '0, '0, 1'b0);
        n = 0;
        while (!vld4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_product", 32'(p4), 32'h0F);
        for (int i = 0; i < 10; i++) begin
            drive(4, 1'b1, 16'h9, 16'h9, 1'b0);
            @(negedge clk);
            check("bp_valid_hold", 32'(vld4), 32'd1);
            check("bp_product_hold", 32'(p4), 32'h0F);
            check("bp_not_ready", 32'(rdy4), 32'd0);
        end
        drive(4, 1'b0, '0, '0, 1'b0);
        r4 = 1'b1;
        @(negedge clk);
        check("bp_released_valid", 32'(vld4), 32'd0);
        check("bp_released_ready", 32'(rdy4), 32'd1);
        op("bp_next", 4, 16'h2, 16'h2, 1'b0, 32'h04);

        // Operands and mode scrambled every cycle after the accept must not matter.
        @(negedge clk);
        drive(4, 1'b1, 16'h6, 16'h5, 1'b0);
        @(negedge clk);
        n = 0;
        while (!vld4 && n < 100) begin
            drive(4, 1'b0, 16'($urandom), 16'($urandom), ~s4);
            @(negedge clk);
            n++;
        end
        drive(4, 1'b0, '0, '0, 1'b0);
        check("toggle_latency", 32'(n), 32'd4);
        check("toggle_product", 32'(p4), 32'h1E);
        @(negedge clk);

        // Reset during the second RUN cycle aborts the operation.
        drive(4, 1'b1, 16'h7, 16'h7, 1'b0);
        @(negedge clk);
        drive(4, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("abort_busy", 32'(busy4), 32'd1);
        rst = 1'b1;
        drive(4, 1'b1, 16'h5, 16'h5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4, 1'b0, '0, '0, 1'b0);
        check("abort_ready", 32'(rdy4), 32'd1);
        check("abort_valid", 32'(vld4), 32'd0);
        check("abort_product", 32'(p4), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_result", 32'(vld4), 32'd0);
        op("after_abort", 4, 16'h3, 16'h3, 1'b0, 32'h09);

        // Width sweep.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    op("n2", 2, 16'(a), 16'(b), 1'(s), ref_mul(2, 16'(a), 16'(b), 1'(s)));
        op("n8_umax", 8, 16'hFF, 16'hFF, 1'b0, 32'hFE01);
        op("n8_smin", 8, 16'h80, 16'h80, 1'b1, 32'h4000);
        op("n16_umax", 16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        op("n16_smin", 16, 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        for (int i = 0; i < 16; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op("n8_rand", 8, ra, rb, 1'(i % 2), ref_mul(8, ra, rb, 1'(i % 2)));
            op("n16_rand", 16, ra, rb, 1'(i % 2), ref_mul(16, ra, rb, 1'(i % 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
